gonso_sequencer: RTL and testbench

- Downstream consumer of the gonso register block.
- Takes the start strobe, word range, iteration count, polarity and prescaler settings from the register block.
- Reads bytes from SRAM read port 1 and serialises them MSB-first as a 3-phase single-wire waveform (high / data / low per bit) on dout.
- Drives progress back to the register block, which raises irq on its falling edge.

---
 rtl/gonso_pkg.sv | 29 ++
 rtl/gonso_prescaler.sv | 26 ++
 rtl/gonso_sequencer.sv | 138 +++++++++++++
 tb/tb_gonso_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gonso_pkg.sv
// Shared types for the gonso sequencer: top-level FSM states and bit-phase encoding.
package gonso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_NEXT
  } state_t;

  typedef enum logic [1:0] {
    PH_HIGH,
    PH_DATA,
    PH_LOW
  } phase_t;

  // Line level (before polarity) for a given phase of the current bit.
  function automatic logic phase_level(input phase_t ph, input logic data_bit);
    logic lvl;
    case (ph)
      PH_HIGH: lvl = 1'b1;
      PH_DATA: lvl = data_bit;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/gonso_prescaler.sv
// Phase-length prescaler: ticks once every prescale+1 clocks while clear is low.
module gonso_prescaler #(
  parameter int unsigned PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PSIZE-1:0] prescale,
  output logic             tick
);

  logic [PSIZE-1:0] cnt;

  assign tick = !clear && (cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PSIZE'(1);
    end
  end

endmodule

// File: rtl/gonso_sequencer.sv
// Reads bytes from SRAM port 1 and serialises them MSB-first as a 3-phase
// (high / data / low) single-wire waveform on dout.
module gonso_sequencer
  import gonso_pkg::*;
#(
  parameter int unsigned ASIZE = 32,
  parameter int unsigned PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             controller_en,
  input  logic [PSIZE-1:0] prescale,
  input  logic             polarity,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             dout
);

  state_t     state;
  phase_t     phase;
  phase_t     phase_nx;
  logic [2:0] bit_idx;
  logic [2:0] bit_nx;
  logic [7:0] shreg;
  logic [3:0] passes;
  logic       level;
  logic       tick;
  logic       byte_done;

  gonso_prescaler #(.PSIZE(PSIZE)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != ST_SHIFT),
    .prescale (prescale),
    .tick     (tick)
  );

  // The level is registered; polarity is applied on the output so the reset
  // value follows polarity without an input-dependent async reset.
  assign dout = level ^ polarity;

  always_comb begin
    phase_nx  = phase;
    bit_nx    = bit_idx;
    byte_done = 1'b0;
    if (tick) begin
      case (phase)
        PH_HIGH: phase_nx = PH_DATA;
        PH_DATA: phase_nx = PH_LOW;
        default: begin
          if (bit_idx != 3'd0) begin
            bit_nx   = 3'(bit_idx - 3'd1);
            phase_nx = PH_HIGH;
          end else begin
            byte_done = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= PH_HIGH;
      bit_idx  <= '0;
      shreg    <= '0;
      passes   <= '0;
      level    <= 1'b0;
      progress <= 1'b0;
      cs_n     <= 1'b1;
      addr     <= '0;
    end else if (state != ST_IDLE && !controller_en) begin
      state    <= ST_IDLE;
      progress <= 1'b0;
      cs_n     <= 1'b1;
      level    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          level <= 1'b0;
          cs_n  <= 1'b1;
          if (start && controller_en) begin
            passes   <= (w_count == 4'd0) ? 4'd1 : w_count;
            addr     <= w_first;
            progress <= 1'b1;
            cs_n     <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          cs_n  <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          shreg   <= rdata;
          bit_idx <= 3'd7;
          phase   <= PH_HIGH;
          level   <= 1'b1;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          phase   <= phase_nx;
          bit_idx <= bit_nx;
          if (byte_done) begin
            level <= 1'b0;
            state <= ST_NEXT;
          end else begin
            level <= phase_level(phase_nx, shreg[bit_nx]);
          end
        end
        ST_NEXT: begin
          if (addr != w_last) begin
            addr  <= addr + ASIZE'(1);
            cs_n  <= 1'b0;
            state <= ST_FETCH;
          end else if (passes > 4'd1) begin
            passes <= passes - 4'd1;
            addr   <= w_first;
            cs_n   <= 1'b0;
            state  <= ST_FETCH;
          end else begin
            progress <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gonso_sequencer.sv
// Self-checking bench: a per-cycle expected waveform is built from the transfer
// parameters and compared against progress/cs_n/addr/dout each cycle.
module tb_gonso_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        controller_en;
  logic [31:0] prescale;
  logic        polarity;
  logic [3:0]  w_count;
  logic [31:0] w_first;
  logic [31:0] w_last;
  logic        start;
  logic        progress;
  logic        cs_n;
  logic [31:0] addr;
  logic [7:0]  rdata;
  logic        dout;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        prog;
    logic        csn;
    logic        dout;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  gonso_sequencer #(.ASIZE(32), .PSIZE(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .controller_en (controller_en),
    .prescale      (prescale),
    .polarity      (polarity),
    .w_count       (w_count),
    .w_first       (w_first),
    .w_last        (w_last),
    .start         (start),
    .progress      (progress),
    .cs_n          (cs_n),
    .addr          (addr),
    .rdata         (rdata),
    .dout          (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read port: data valid one clock after cs_n low.
  always @(posedge clk) if (!cs_n) rdata <= mem[addr[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic build(input logic [31:0] first, input logic [31:0] last, input logic [3:0] wc,
                       input int ps, input logic pol);
    int np;
    logic [31:0] a;
    logic [7:0]  b;
    logic        lvl;
    q.delete();
    np = (wc == 4'd0) ? 1 : int'(wc);
    for (int p = 0; p < np; p++) begin
      a = first;
      forever begin
        q.push_back('{1'b1, 1'b0, pol, a});
        q.push_back('{1'b1, 1'b1, pol, 32'd0});
        b = mem[a[7:0]];
        for (int k = 7; k >= 0; k--) begin
          for (int ph = 0; ph < 3; ph++) begin
            lvl = (ph == 0) ? 1'b1 : (ph == 1) ? b[k] : 1'b0;
            for (int c = 0; c <= ps; c++) q.push_back('{1'b1, 1'b1, lvl ^ pol, 32'd0});
          end
        end
        q.push_back('{1'b1, 1'b1, pol, 32'd0});
        if (a == last) break;
        a = a + 32'd1;
      end
    end
  endtask

  task automatic run_xfer(input logic [31:0] first, input logic [31:0] last, input logic [3:0] wc,
                          input int ps, input logic pol, input int abort_at, input int restart_at);
    @(negedge clk);
    w_first  = first;
    w_last   = last;
    w_count  = wc;
    prescale = 32'(ps);
    polarity = pol;
    build(first, last, wc, ps, pol);
    if (abort_at >= 0 && abort_at < q.size()) q = q[0:abort_at];
    repeat (4) q.push_back('{1'b0, 1'b1, pol, 32'd0});
    @(negedge clk);
    check("idle_prog", 32'(progress), 32'd0);
    check("idle_dout", 32'(dout), 32'(pol));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w_count = 4'($urandom_range(15, 0));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      check("progress", 32'(progress), 32'(q[i].prog));
      check("cs_n", 32'(cs_n), 32'(q[i].csn));
      check("dout", 32'(dout), 32'(q[i].dout));
      if (q[i].csn == 1'b0) check("addr", addr, q[i].addr);
      if (i == restart_at) start = 1'b1;
      if (i == abort_at) controller_en = 1'b0;
    end
    controller_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    controller_en = 1'b1;
    prescale = '0;
    polarity = 1'b0;
    w_count = 4'd1;
    w_first = '0;
    w_last = '0;
    start = 1'b0;
    rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #12;
    check("rst_prog", 32'(progress), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_addr", addr, 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mem[8'h10] = 8'hA5;
    run_xfer(32'h10, 32'h10, 4'd1, 0, 1'b0, -1, -1);

    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h81;
    run_xfer(32'h0, 32'h2, 4'd2, 3, 1'b0, -1, -1);

    run_xfer(32'h10, 32'h10, 4'd0, 0, 1'b0, -1, 10);
    run_xfer(32'h0, 32'h2, 4'd2, 0, 1'b0, -1, 40);

    run_xfer(32'h20, 32'h23, 4'd1, 1, 1'b0, 60, -1);
    run_xfer(32'h20, 32'h23, 4'd1, 1, 1'b0, -1, -1);

    mem[8'h30] = 8'h00;
    run_xfer(32'h30, 32'h30, 4'd1, 1, 1'b1, -1, -1);

    // Asynchronous reset in the middle of a byte, polarity inverted.
    @(negedge clk);
    w_first = 32'h40; w_last = 32'h42; w_count = 4'd3; prescale = 32'd2; polarity = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_prog", 32'(progress), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_prog", 32'(progress), 32'd0);
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_dout", 32'(dout), 32'd1);
    check("arst_addr", addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_prog", 32'(progress), 32'd0);
      check("post_rst_cs_n", 32'(cs_n), 32'd1);
      check("post_rst_dout", 32'(dout), 32'd1);
    end

    for (int t = 0; t < 6; t++) begin
      logic [31:0] f;
      f = 32'($urandom_range(200, 0));
      run_xfer(f, f + 32'($urandom_range(2, 0)), 4'($urandom_range(3, 0)),
               int'($urandom_range(2, 0)), 1'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
